// File: rtl/mux_n_choice.sv
// mux_n_choice: registered N-way data selector with valid/ready handshaking and select-error tracking.
// Build option MUX_N_CHOICE_SKID_EN adds a two-entry skid buffer so that in_ready comes from a register.
module mux_n_choice #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 3,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] choices,
    input  logic [SEL_W-1:0]          select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          mux_output,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    output logic [7:0]                drop_cnt,
    input  logic                      err_clr
);

    localparam int NSLOT = 2 ** SEL_W;
    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    // Unused slots are padded with zero so that any select value indexes a real entry.
    logic [WIDTH-1:0] choice_a [NSLOT];

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < CHANNELS) begin : g_used
            assign choice_a[k] = choices[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign choice_a[k] = '0;
        end
    end

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic in_range, accept, take_ok, take_bad, out_free;

    assign in_range = {1'b0, select} < CH_LIMIT;
    assign accept   = in_valid & in_ready;
    assign take_ok  = accept & in_range;
    assign take_bad = accept & ~in_range;
    assign out_free = ~valid_q | out_ready;

    // NOTE: every signal written here gets a default first, so no path can leave a latch.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
            cnt_d = 8'd0;
        end
        if (take_bad) begin
            err_d = 1'b1;
            if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
        end
    end

`ifdef MUX_N_CHOICE_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_valid_q, skid_valid_d;

    assign in_ready = ~skid_valid_q & ~rst;

    always_comb begin
        data_d       = data_q;
        sel_d        = sel_q;
        valid_d      = valid_q & ~out_ready;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (out_free) begin
                data_d       = skid_data_q;
                sel_d        = skid_sel_q;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (take_ok) begin
            if (out_free) begin
                data_d  = choice_a[select];
                sel_d   = select;
                valid_d = 1'b1;
            end else begin
                skid_data_d  = choice_a[select];
                skid_sel_d   = select;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = ~rst & out_free;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q & ~out_ready;
        if (take_ok) begin
            data_d  = choice_a[select];
            sel_d   = select;
            valid_d = 1'b1;
        end
    end
`endif

    // NOTE: the data registers are reset as well because mux_output/out_sel must read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mux_output = data_q;
    assign out_sel    = sel_q;
    assign out_valid  = valid_q;
    assign sel_err    = err_q;
    assign drop_cnt   = cnt_q;

endmodule

// File: tb/tb_mux_n_choice.sv
// Directed bench for mux_n_choice: a 24-bit/3-channel instance and an 8-bit/16-channel instance.
module tb_mux_n_choice;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] choices;
    logic [1:0]  select;
    logic        in_valid, in_ready, out_valid, out_ready, sel_err, err_clr;
    logic [23:0] mux_output;
    logic [1:0]  out_sel;
    logic [7:0]  drop_cnt;

    logic [127:0] choices16;
    logic [3:0]   select16, out_sel16;
    logic         in_valid16, in_ready16, out_valid16, out_ready16, sel_err16, err_clr16;
    logic [7:0]   mux_output16, drop_cnt16;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [71:0] CH_A = {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};

    always #5 clk = ~clk;

    mux_n_choice #(.WIDTH(24), .CHANNELS(3), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .choices(choices), .select(select),
        .in_valid(in_valid), .in_ready(in_ready), .mux_output(mux_output),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .drop_cnt(drop_cnt), .err_clr(err_clr)
    );

    mux_n_choice #(.WIDTH(8), .CHANNELS(16), .SEL_W(4)) dut16 (
        .clk(clk), .rst(rst), .choices(choices16), .select(select16),
        .in_valid(in_valid16), .in_ready(in_ready16), .mux_output(mux_output16),
        .out_sel(out_sel16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sel_err(sel_err16), .drop_cnt(drop_cnt16), .err_clr(err_clr16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [23:0] exp_d [4];
        logic [1:0]  exp_s [4];
        int          idx;
        int          got;
        logic        acc;
        logic        del;

        exp_d[0] = 24'hAAAAAA; exp_s[0] = 2'd0;
        exp_d[1] = 24'hBBBBBB; exp_s[1] = 2'd1;
        exp_d[2] = 24'hCCCCCC; exp_s[2] = 2'd2;
        exp_d[3] = 24'hAAAAAA; exp_s[3] = 2'd0;

        rst = 1'b1; choices = CH_A; select = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        for (int k = 0; k < 16; k++) choices16[k*8 +: 8] = {4'(k), 4'(15 - k)};
        select16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b1; err_clr16 = 1'b0;

        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_mux_output", mux_output, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid16", out_valid16, 0);

        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);

        // Single in-range transfer, delivered immediately
        select = 2'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("sel1_valid", out_valid, 1);
        check("sel1_data", mux_output, 24'hBBBBBB);
        check("sel1_sel", out_sel, 1);
        check("sel1_no_err", sel_err, 0);
        tick();
        check("sel1_one_cycle", out_valid, 0);
        check("sel1_retained", mux_output, 24'hBBBBBB);
        check("sel1_sel_retained", out_sel, 1);

        // Out-of-range select after a valid 0xAAAAAA result
        select = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("sel0_data", mux_output, 24'hAAAAAA);
        check("sel0_valid", out_valid, 1);
        tick();
        select = 2'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("oor_data_kept", mux_output, 24'hAAAAAA);
        check("oor_sel_kept", out_sel, 0);
        check("oor_valid_kept", out_valid, 0);
        check("oor_sel_err", sel_err, 1);
        check("oor_drop_cnt", drop_cnt, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_sel_err", sel_err, 0);
        check("clr_drop_cnt", drop_cnt, 0);

        // 300 back-to-back out-of-range accepts saturate the counter
        select = 2'd3; in_valid = 1'b1;
        repeat (254) tick();
        check("drop_254", drop_cnt, 254);
        repeat (46) tick();
        in_valid = 1'b0;
        check("drop_sat", drop_cnt, 255);
        check("drop_sat_err", sel_err, 1);
        check("drop_sat_no_output", out_valid, 0);

        // Clear coinciding with an out-of-range accept
        select = 2'd3; in_valid = 1'b1; err_clr = 1'b1;
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        check("clr_race_err", sel_err, 1);
        check("clr_race_cnt", drop_cnt, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr2_cnt", drop_cnt, 0);

        // Stream 0,1,2,0 with the consumer stalled in cycles 2-3
        idx = 0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid  = (idx < 4);
            select    = (idx < 4) ? exp_s[idx] : 2'd0;
            out_ready = !(c == 2 || c == 3);
            #1;
            if (out_valid && got < 4) begin
                check("stream_data", mux_output, exp_d[got]);
                check("stream_sel", out_sel, exp_s[got]);
            end else if (out_valid) begin
                check("stream_extra", out_valid, 0);
            end
            acc = in_valid & in_ready;
            del = out_valid & out_ready;
            @(posedge clk);
            if (acc) idx++;
            if (del) got++;
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_accepted", idx, 4);
        check("stream_delivered", got, 4);
        check("stream_no_err", sel_err, 0);

        // Choices changing without an accept must not reach the output
        choices = {24'h333333, 24'h222222, 24'h111111};
        tick();
        check("no_accept_data", mux_output, 24'hAAAAAA);
        select = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("new_choice_data", mux_output, 24'h333333);
        check("new_choice_sel", out_sel, 2);
        choices = CH_A;
        tick();

        // Asynchronous reset between edges with a result held and a transfer in flight
        select = 2'd3; in_valid = 1'b1;
        tick();
        select = 2'd2; out_ready = 1'b0;
        tick();
        select = 2'd1;
        tick();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_err", sel_err, 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", mux_output, 0);
        check("async_rst_sel", out_sel, 0);
        check("async_rst_err", sel_err, 0);
        check("async_rst_cnt", drop_cnt, 0);
        check("async_rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0; select = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", mux_output, 24'hBBBBBB);
        check("post_rst_sel", out_sel, 1);
        tick();
        check("post_rst_no_dup", out_valid, 0);

        // 16-channel sweep
        in_valid16 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            select16 = 4'(k);
            tick();
            check("sweep_valid", out_valid16, 1);
            check("sweep_sel", out_sel16, k);
            check("sweep_data", mux_output16, {4'(k), 4'(15 - k)});
        end
        in_valid16 = 1'b0;
        check("sweep_no_err", sel_err16, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
